aes_dec_iter: RTL and testbench

- Iterative AES inverse cipher; successor to the fully unrolled 14-round decrypt datapath.
- Parametrised key length (AES-128/192/256). One round per clock through a single shared round datapath.
- Valid/ready handshakes on input and output; full block and round-key chain latched on accept.
- Sits between the key-schedule/host buffer and the plaintext sink; reuses the team's existing primitives: add_round_key, decryption_rounds, inv_shift_rows, inv_sub_bytes.

---
 rtl/aes_dec_iter.sv | 250 +++++++++++++++++++++++++
 tb/tb_aes_dec_iter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter.sv
// ----------------------------------------------------------------------------
// aes_dec_iter -- iterative AES inverse cipher, one round per clock.
//
// A block and its complete round-key chain are latched when the input is
// accepted. After that the block runs through a single shared round datapath,
// one round per clock. The plaintext is held until the sink takes it.
//
// Parameters
//   KEY_BITS : 128 / 192 / 256 (anything else stops elaboration)
//   NR       : round count 10 / 12 / 14 (derived)
//   KC_W     : key chain width, 128*(NR+1) (derived)
//
// Ports
//   clk_i         in   clock
//   reset_i       in   asynchronous, active-high reset
//   in_valid_i    in   ciphertext_i / key_chain_i valid
//   in_ready_o    out  high in IDLE only; accept = in_valid_i && in_ready_o
//   ciphertext_i  in   128-bit input block
//   key_chain_i   in   round keys in decrypt order, step k uses [k*128 +: 128]
//   out_valid_o   out  plaintext_o valid, held until out_ready_i
//   out_ready_i   in   sink accepts plaintext_o
//   plaintext_o   out  registered result block
//   busy_o        out  high in ROUND or DONE
//   blk_count_o   out  (AES_DEC_BLOCK_COUNT_EN only) wrapping count of
//                      output handshakes
//
// Optional feature macro: AES_DEC_BLOCK_COUNT_EN
// ----------------------------------------------------------------------------
module aes_dec_iter #(
    parameter int  KEY_BITS = 256,
    localparam int NR       = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14,
    localparam int KC_W     = 128 * (NR + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [127:0]      ciphertext_i,
    input  logic [KC_W-1:0]   key_chain_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      plaintext_o,
    output logic              busy_o
`ifdef AES_DEC_BLOCK_COUNT_EN
    ,
    output logic [31:0]       blk_count_o
`endif
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_dec_iter: KEY_BITS must be 128, 192 or 256");
    end

    localparam int            RW   = $clog2(NR + 1);
    localparam logic [RW-1:0] NR_R = RW'(NR);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // ------------------------------------------------------------------------
    // Round primitives. State byte i (column-major, r + 4c) sits at
    // [127-8*i -: 8], matching the FIPS-197 byte order of the hex vectors.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                // Row r rotates right by r: out[r][c] = in[r][c-r].
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] rk);
        return s ^ rk;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                a[j]  = s[127 - 8*(4*c + j) -: 8];
                x2[j] = xtime(a[j]);
                x4[j] = xtime(x2[j]);
                x8[j] = xtime(x4[j]);
                m9[j] = x8[j] ^ a[j];
                mb[j] = x8[j] ^ x2[j] ^ a[j];
                md[j] = x8[j] ^ x4[j] ^ a[j];
                me[j] = x8[j] ^ x4[j] ^ x2[j];
            end
            o[127 - 8*(4*c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127 - 8*(4*c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127 - 8*(4*c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127 - 8*(4*c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    // Full middle round of the (non-equivalent) inverse cipher.
    function automatic logic [127:0] decryption_rounds(input logic [127:0] s,
                                                       input logic [127:0] rk);
        return inv_mix_columns(add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk));
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    state_e          fsm_q, fsm_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [127:0]    st_q, st_d;
    logic [KC_W-1:0] key_q, key_d;
    logic [127:0]    pt_q, pt_d;
    logic            out_valid_q, out_valid_d;
`ifdef AES_DEC_BLOCK_COUNT_EN
    logic [31:0]     blk_count_q, blk_count_d;
`endif

    // Latched chain split into per-step round keys so the round counter can
    // index it directly.
    logic [127:0] rk [NR+1];
    for (genvar k = 0; k <= NR; k++) begin : g_rk
        assign rk[k] = key_q[k*128 +: 128];
    end

    logic [127:0] rk_cur;
    logic [127:0] round_out;
    logic [127:0] final_out;

    assign rk_cur    = rk[rnd_q];
    assign round_out = decryption_rounds(st_q, rk_cur);
    // Last round skips InvMixColumns.
    assign final_out = add_round_key(inv_sub_bytes(inv_shift_rows(st_q)), rk_cur);

    always_comb begin
        // NOTE: every *_d gets its hold value first, so branches that do not
        // assign it cannot infer a latch.
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        key_d       = key_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
`ifdef AES_DEC_BLOCK_COUNT_EN
        blk_count_d = blk_count_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    key_d = key_chain_i;
                    st_d  = ciphertext_i ^ key_chain_i[127:0];
                    rnd_d = RW'(1);
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q == NR_R) begin
                    pt_d        = final_out;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    st_d  = round_out;
                    rnd_d = rnd_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
`ifdef AES_DEC_BLOCK_COUNT_EN
                    blk_count_d = blk_count_q + 32'd1;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the wide key register is reset too; an abort must leave
            // no key material behind in the block.
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_DEC_BLOCK_COUNT_EN
            blk_count_q <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
`ifdef AES_DEC_BLOCK_COUNT_EN
            blk_count_q <= blk_count_d;
`endif
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign busy_o      = (fsm_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign plaintext_o = pt_q;
`ifdef AES_DEC_BLOCK_COUNT_EN
    assign blk_count_o = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_dec_iter.sv
// ----------------------------------------------------------------------------
// tb_aes_dec_iter -- directed bench for aes_dec_iter with one instance per key
// length (index 0 = AES-128, 1 = AES-192, 2 = AES-256). The bench builds the
// reversed round-key chains from the FIPS-197 cipher keys with its own key
// expansion. It checks the known plaintexts, output latency, backpressure,
// input isolation after accept and reset in mid-block.
// ----------------------------------------------------------------------------
module tb_aes_dec_iter;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic           clk;
    logic           reset_i;
    logic [2:0]     in_valid;
    logic [2:0]     in_ready;
    logic [2:0]     out_valid;
    logic [2:0]     busy;
    logic           out_ready;
    logic [127:0]   ct_in;
    logic [1919:0]  kc_in;
    logic [127:0]   pt [3];
`ifdef AES_DEC_BLOCK_COUNT_EN
    logic [31:0]    bc [3];
`endif

    int n_vec = 0;
    int n_err = 0;

    aes_dec_iter #(.KEY_BITS(128)) u_dut128 (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .ciphertext_i(ct_in), .key_chain_i(kc_in[1407:0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready), .plaintext_o(pt[0]), .busy_o(busy[0])
`ifdef AES_DEC_BLOCK_COUNT_EN
        , .blk_count_o(bc[0])
`endif
    );

    aes_dec_iter #(.KEY_BITS(192)) u_dut192 (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .ciphertext_i(ct_in), .key_chain_i(kc_in[1663:0]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready), .plaintext_o(pt[1]), .busy_o(busy[1])
`ifdef AES_DEC_BLOCK_COUNT_EN
        , .blk_count_o(bc[1])
`endif
    );

    aes_dec_iter #(.KEY_BITS(256)) u_dut256 (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .ciphertext_i(ct_in), .key_chain_i(kc_in), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready), .plaintext_o(pt[2]), .busy_o(busy[2])
`ifdef AES_DEC_BLOCK_COUNT_EN
        , .blk_count_o(bc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // FIPS-197 key expansion. The key is left-aligned in 256 bits. The chain
    // puts round key NR-k in slice k.
    function automatic logic [1919:0] build_chain(input int nk, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] chain;
        int            nr;
        int            r;
        nr    = nk + 6;
        rc    = 8'h01;
        chain = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k <= nr; k++) begin
            r = nr - k;
            chain[k*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return chain;
    endfunction

    // Present one block to instance d with out_ready high. Starts and ends
    // #1 after a rising edge with the instance idle.
    task automatic run_one(input int d, input logic [127:0] ct, input logic [1919:0] chain,
                           input logic [127:0] exp, input int lat, input bit corrupt,
                           input string nm);
        int n;
        ct_in       = ct;
        kc_in       = chain;
        in_valid[d] = 1'b1;
        check({nm, " in_ready before accept"}, 128'(in_ready[d]), 128'(1));
        tick();                                     // accept edge
        in_valid[d] = 1'b0;
        if (corrupt) begin
            ct_in = '1;
            kc_in = '1;
        end
        n = 0;
        while (!out_valid[d] && n < lat + 4) begin
            tick();
            n++;
        end
        check({nm, " latency"}, 128'(n), 128'(lat));
        check({nm, " plaintext"}, pt[d], exp);
        tick();
        check({nm, " out_valid single cycle"}, 128'(out_valid[d]), 128'(0));
        check({nm, " in_ready after retire"}, 128'(in_ready[d]), 128'(1));
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        string        name;
        int           dut;
        int           nk;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    vec_t vecs [4];

    initial begin
        logic [1919:0] chain256;
        int            n;
        int            highs;

        vecs[0] = '{"C.1 aes128", 0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_STD, 10};
        vecs[1] = '{"C.2 aes192", 1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_STD, 12};
        vecs[2] = '{"C.3 aes256", 2, 8, KEY_256, CT_256, PT_STD, 14};
        vecs[3] = '{"B aes128", 0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 10};
        chain256 = build_chain(8, KEY_256);

        reset_i   = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        ct_in     = '0;
        kc_in     = '0;

        // Reset values, sampled while reset is held.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset in_ready[%0d]", d), 128'(in_ready[d]), 128'(1));
            check($sformatf("reset out_valid[%0d]", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("reset busy[%0d]", d), 128'(busy[d]), 128'(0));
            check($sformatf("reset plaintext[%0d]", d), pt[d], 128'h0);
        end
        reset_i = 1'b0;
        tick();

        // Table-driven known-answer vectors.
        for (int i = 0; i < 4; i++) begin
            run_one(vecs[i].dut, vecs[i].ct, build_chain(vecs[i].nk, vecs[i].key),
                    vecs[i].pt, vecs[i].lat, 1'b0, vecs[i].name);
        end

        // plaintext_o keeps the last result while idle.
        repeat (3) tick();
        check("idle hold plaintext", pt[2], PT_STD);

        // Inputs trashed the cycle after accept must not disturb the block.
        run_one(2, CT_256, chain256, PT_STD, 14, 1'b1, "input change after accept");

        // Output backpressure, with the next block already waiting upstream.
        out_ready   = 1'b0;
        ct_in       = CT_256;
        kc_in       = chain256;
        in_valid[2] = 1'b1;
        tick();                                     // accept edge
        n = 0;
        while (!out_valid[2] && n < 18) begin
            tick();
            n++;
        end
        check("backpressure latency", 128'(n), 128'(14));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp hold plaintext %0d", i), pt[2], PT_STD);
            check($sformatf("bp hold out_valid %0d", i), 128'(out_valid[2]), 128'(1));
            check($sformatf("bp in_ready low %0d", i), 128'(in_ready[2]), 128'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();                                     // retire edge
        check("bp retire out_valid", 128'(out_valid[2]), 128'(0));
        check("bp idle before re-accept", 128'(in_ready[2]), 128'(1));
        tick();                                     // second accept edge
        check("bp second accepted", 128'(busy[2]), 128'(1));
        in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid[2] && n < 18) begin
            tick();
            n++;
        end
        check("bp second latency", 128'(n), 128'(14));
        check("bp second plaintext", pt[2], PT_STD);
        tick();

        // Reset in the middle of a block.
        ct_in       = CT_256;
        kc_in       = chain256;
        in_valid[2] = 1'b1;
        tick();                                     // accept, rnd = 1
        in_valid[2] = 1'b0;
        repeat (4) tick();                          // rnd = 5
        check("pre-abort busy", 128'(busy[2]), 128'(1));
        reset_i = 1'b1;
        #1;
        check("abort in_ready", 128'(in_ready[2]), 128'(1));
        check("abort busy", 128'(busy[2]), 128'(0));
        check("abort out_valid", 128'(out_valid[2]), 128'(0));
        check("abort plaintext cleared", pt[2], 128'h0);
        tick();
        reset_i = 1'b0;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid[2]) highs++;
            tick();
        end
        check("abort no out_valid pulse", 128'(highs), 128'(0));
        run_one(2, CT_256, chain256, PT_STD, 14, 1'b0, "after abort");

`ifdef AES_DEC_BLOCK_COUNT_EN
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("blk_count reset", 128'(bc[2]), 128'(0));
        for (int i = 0; i < 3; i++) begin
            run_one(2, CT_256, chain256, PT_STD, 14, 1'b0, $sformatf("count blk %0d", i));
        end
        check("blk_count three", 128'(bc[2]), 128'(3));
        force u_dut256.blk_count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut256.blk_count_q;
        tick();
        check("blk_count forced", 128'(bc[2]), 128'(32'hFFFF_FFFF));
        run_one(2, CT_256, chain256, PT_STD, 14, 1'b0, "count wrap");
        check("blk_count wrap", 128'(bc[2]), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
